// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: load/ready handshake, one bit per clk on sout.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic accept;

  // ready (and done) open the slot for the next word so frames chain without a bubble
`ifdef PISO_PARITY_EN
  assign ready = (state_q == IDLE) || (state_q == PARITY);
`else
  assign ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
`endif
  assign done       = ready && (state_q != IDLE);
  assign accept     = load && ready;
  assign sout       = sout_q;
  assign sout_valid = vld_q;
  assign busy       = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      // The first bit goes straight to sout; the register keeps the remainder pre-shifted.
      sout_d  = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
      sreg_d  = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
      cnt_d   = '0;
      vld_d   = 1'b1;
      busy_d  = 1'b1;
      state_d = SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST) begin
            cnt_d  = cnt_q + 1'b1;
            sout_d = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
            sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            sout_d  = par_q;
`else
            state_d = IDLE;
            sout_d  = 1'b0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
`endif
          end
        end
        PARITY: begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
